// File: rtl/oam_dma_if.sv
// Bus bundle for the OAM DMA engine: CPU responder side plus the initiator side it drives.
// The slave modport is the DMA block's view; master is the surrounding system's view.
interface oam_dma_if;
  logic [15:0] address;
  logic [7:0]  outdata;
  logic [7:0]  data;
  logic        load;
  logic        store;
  logic [15:0] dma_address;
  logic [7:0]  dma_outdata;
  logic [7:0]  dma_indata;
  logic        dma_load;
  logic        dma_store;
  logic        busy;

  modport slave (
    input  address, outdata, load, store, dma_indata,
    output data, dma_address, dma_outdata, dma_load, dma_store, busy
  );

  modport master (
    output address, outdata, load, store, dma_indata,
    input  data, dma_address, dma_outdata, dma_load, dma_store, busy
  );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA engine: a write to REG_ADDR copies LENGTH bytes from {src,8'h00} into OAM_BASE.
// Define OAM_DMA_RESTART_EN to let a register write during a transfer restart it.
module oam_dma #(
  parameter logic [15:0] REG_ADDR = 16'hff46,
  parameter logic [15:0] OAM_BASE = 16'hfe00,
  parameter int          LENGTH   = 160
) (
  input logic       clockgb,
  input logic       resetn,
  oam_dma_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(LENGTH - 1);

`ifdef OAM_DMA_RESTART_EN
  localparam logic RESTART = 1'b1;
`else
  localparam logic RESTART = 1'b0;
`endif

  // Sources E0-FF mirror onto C0-DF (echo RAM).
  function automatic logic [7:0] echo_high(input logic [7:0] hi);
    logic [7:0] res;
    if (hi >= 8'he0) begin
      res = hi - 8'h20;
    end else begin
      res = hi;
    end
    return res;
  endfunction

  state_t      state_r, state_s;
  logic [7:0]  i_r, i_s;
  logic [7:0]  src_hi_r, src_hi_s;
  logic [7:0]  src_act_r, src_act_s;
  logic [15:0] dma_address_r, dma_address_s;
  logic [7:0]  dma_outdata_r, dma_outdata_s;
  logic        dma_load_r, dma_load_s;
  logic        dma_store_r, dma_store_s;
  logic        busy_r, busy_s;
  logic        reg_wr_s;
  logic        start_s;
  logic [7:0]  data_s;

  assign reg_wr_s = bus.store && (bus.address == REG_ADDR);
  assign start_s  = reg_wr_s && ((state_r == IDLE) || RESTART);

  // Next-state logic; src_act keeps the source of the running transfer, src_hi is readback only.
  always_comb begin
    state_s   = state_r;
    i_s       = i_r;
    src_act_s = src_act_r;
    src_hi_s  = reg_wr_s ? bus.outdata : src_hi_r;
    if (start_s) begin
      state_s   = READ;
      i_s       = 8'h00;
      src_act_s = bus.outdata;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = IDLE;
        end
        READ: begin
          state_s = WRITE;
        end
        WRITE: begin
          i_s = i_r + 8'h01;
          if (i_r == LAST_IDX) begin
            state_s = IDLE;
          end else begin
            state_s = READ;
          end
        end
        default: begin
          state_s = IDLE;
          i_s     = 8'h00;
        end
      endcase
    end
  end

  // Next-cycle bus outputs, decoded from the next state so they can be registered.
  always_comb begin
    dma_address_s = 16'h0000;
    dma_outdata_s = 8'h00;
    dma_load_s    = 1'b0;
    dma_store_s   = 1'b0;
    busy_s        = 1'b0;
    case (state_s)
      READ: begin
        dma_address_s = {echo_high(src_act_s), 8'h00} + {8'h00, i_s};
        dma_load_s    = 1'b1;
        busy_s        = 1'b1;
      end
      WRITE: begin
        // Only reached from READ, so this is the byte returned by the read just finishing.
        dma_address_s = OAM_BASE + {8'h00, i_s};
        dma_outdata_s = bus.dma_indata;
        dma_store_s   = 1'b1;
        busy_s        = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clockgb) begin
    if (!resetn) begin
      state_r       <= IDLE;
      i_r           <= 8'h00;
      src_hi_r      <= 8'h00;
      src_act_r     <= 8'h00;
      dma_address_r <= 16'h0000;
      dma_outdata_r <= 8'h00;
      dma_load_r    <= 1'b0;
      dma_store_r   <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      i_r           <= i_s;
      src_hi_r      <= src_hi_s;
      src_act_r     <= src_act_s;
      dma_address_r <= dma_address_s;
      dma_outdata_r <= dma_outdata_s;
      dma_load_r    <= dma_load_s;
      dma_store_r   <= dma_store_s;
      busy_r        <= busy_s;
    end
  end

  // Register readback onto the wired-OR CPU bus.
  always_comb begin
    if (bus.load && (bus.address == REG_ADDR)) begin
      data_s = src_hi_r;
    end else begin
      data_s = 8'h00;
    end
  end

  assign bus.data        = data_s;
  assign bus.dma_address = dma_address_r;
  assign bus.dma_outdata = dma_outdata_r;
  assign bus.dma_load    = dma_load_r;
  assign bus.dma_store   = dma_store_r;
  assign bus.busy        = busy_r;

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: expected reads/writes are queued at stimulus time, a negedge monitor pops and compares.
module tb_oam_dma;

  logic clockgb = 1'b0;
  logic resetn  = 1'b0;
  always #5 clockgb = ~clockgb;

  oam_dma_if bus();

  oam_dma dut (
    .clockgb (clockgb),
    .resetn  (resetn),
    .bus     (bus.slave)
  );

  logic [7:0]  mem [0:65535];
  logic [15:0] rd_q [$];
  logic [23:0] wr_q [$];
  int          checks = 0;
  int          errors = 0;
  int          st_cnt = 0;
  logic        rd_seen = 1'b0;
  logic [15:0] first_rd = 16'h0000;
  logic [15:0] last_rd  = 16'h0000;
  logic [7:0]  prev_indata = 8'h00;

  assign bus.dma_indata = bus.dma_load ? mem[bus.dma_address] : 8'h00;

  always @(posedge clockgb) begin
    if (bus.dma_store) mem[bus.dma_address] = bus.dma_outdata;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: compares every strobe the DUT presents against the queued expectations.
  always @(negedge clockgb) begin
    logic [15:0] ea;
    logic [23:0] ew;
    if (bus.dma_load || bus.dma_store)
      chk("load_store_exclusive", {31'b0, bus.dma_load & bus.dma_store}, 32'h0);
    if (bus.dma_load) begin
      last_rd = bus.dma_address;
      if (!rd_seen) begin
        first_rd = bus.dma_address;
        rd_seen  = 1'b1;
      end
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected: got %h expected no read", bus.dma_address);
      end else begin
        ea = rd_q.pop_front();
        chk("rd_addr", {16'h0, bus.dma_address}, {16'h0, ea});
      end
    end
    if (bus.dma_store) begin
      st_cnt++;
      chk("wr_follows_indata", {24'h0, bus.dma_outdata}, {24'h0, prev_indata});
      if (wr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr_unexpected: got %h expected no write", bus.dma_address);
      end else begin
        ew = wr_q.pop_front();
        chk("wr_addr", {16'h0, bus.dma_address}, {16'h0, ew[23:8]});
        chk("wr_data", {24'h0, bus.dma_outdata}, {24'h0, ew[7:0]});
      end
    end
    prev_indata = bus.dma_indata;
  end

  // Preload source bytes k^seed and queue the 160 reads and writes the transfer must make.
  task automatic push_xfer(input logic [7:0] src, input logic [7:0] seed);
    logic [7:0]  eff;
    logic [15:0] a;
    eff = (src >= 8'he0) ? (src - 8'h20) : src;
    for (int k = 0; k < 160; k++) begin
      a = {eff, 8'h00} + 16'(k);
      mem[a] = 8'(k) ^ seed;
      rd_q.push_back(a);
      wr_q.push_back({16'hfe00 + 16'(k), 8'(k) ^ seed});
    end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(posedge clockgb); #1;
    bus.address = a; bus.outdata = d; bus.store = 1'b1;
    @(posedge clockgb); #1;
    bus.address = 16'h0000; bus.outdata = 8'h00; bus.store = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
    bus.address = a; bus.load = 1'b1;
    #1;
    d = bus.data;
    bus.load = 1'b0; bus.address = 16'h0000;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (bus.busy && n < 1000) begin
      n++;
      @(posedge clockgb); #1;
    end
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_busy"}, {31'b0, bus.busy}, 32'h0);
    chk({nm, "_addr"}, {16'h0, bus.dma_address}, 32'h0);
    chk({nm, "_load"}, {31'b0, bus.dma_load}, 32'h0);
    chk({nm, "_store"}, {31'b0, bus.dma_store}, 32'h0);
    chk({nm, "_outdata"}, {24'h0, bus.dma_outdata}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    int         st0;
    logic [7:0] rb;
    bus.address = 16'h0000; bus.outdata = 8'h00; bus.load = 1'b0; bus.store = 1'b0;
    for (int k = 0; k < 256; k++) mem[16'hfe00 + 16'(k)] = 8'hee;

    // Reset state
    repeat (2) @(posedge clockgb);
    #1;
    chk_quiet("reset");
    cpu_read(16'hff46, rb);
    chk("reset_readback", {24'h0, rb}, 32'h0);
    resetn = 1'b1;

    // Write to another address is ignored
    cpu_write(16'hff47, 8'hc0);
    chk_quiet("ignored_write");
    cpu_read(16'hff46, rb);
    chk("ignored_readback", {24'h0, rb}, 32'h0);

    // Basic transfer from C000
    push_xfer(8'hc0, 8'h5a);
    st0 = st_cnt;
    cpu_write(16'hff46, 8'hc0);
    wait_busy(n);
    chk("xfer1_busy_cycles", n, 320);
    chk("xfer1_stores", st_cnt - st0, 160);
    chk("xfer1_rd_left", rd_q.size(), 0);
    chk("xfer1_wr_left", wr_q.size(), 0);
    chk("xfer1_fe00", {24'h0, mem[16'hfe00]}, 32'h5a);
    chk("xfer1_fe9f", {24'h0, mem[16'hfe9f]}, 32'hc5);
    chk("xfer1_fea0", {24'h0, mem[16'hfea0]}, 32'hee);
    chk_quiet("xfer1_idle");

    // Echo source F1 -> D1xx
    rd_seen = 1'b0;
    push_xfer(8'hf1, 8'h33);
    cpu_write(16'hff46, 8'hf1);
    wait_busy(n);
    chk("echo_busy_cycles", n, 320);
    chk("echo_first_rd", {16'h0, first_rd}, 32'hd100);
    chk("echo_last_rd", {16'h0, last_rd}, 32'hd19f);
    cpu_read(16'hff46, rb);
    chk("echo_readback", {24'h0, rb}, 32'hf1);

    // Readback during a transfer
    push_xfer(8'h80, 8'hc3);
    cpu_write(16'hff46, 8'h80);
    cpu_read(16'hff46, rb);
    chk("rb_ff46", {24'h0, rb}, 32'h80);
    cpu_read(16'hff47, rb);
    chk("rb_ff47", {24'h0, rb}, 32'h0);
    wait_busy(n);
    chk("rb_busy_cycles", n, 320);

    // Reset during cycle 100 of a transfer
    for (int k = 0; k < 256; k++) mem[16'hfe00 + 16'(k)] = 8'hee;
    push_xfer(8'hc0, 8'h5a);
    cpu_write(16'hff46, 8'hc0);
    repeat (99) begin @(posedge clockgb); #1; end
    resetn = 1'b0;
    @(posedge clockgb); #1;
    chk_quiet("abort");
    resetn = 1'b1;
    chk("abort_rd_left", rd_q.size(), 110);
    chk("abort_wr_left", wr_q.size(), 110);
    rd_q.delete();
    wr_q.delete();
    repeat (10) begin @(posedge clockgb); #1; end
    chk("abort_busy_later", {31'b0, bus.busy}, 32'h0);
    chk("abort_fe31", {24'h0, mem[16'hfe31]}, 32'h6b);
    chk("abort_fe32", {24'h0, mem[16'hfe32]}, 32'hee);
    chk("abort_fe9f", {24'h0, mem[16'hfe9f]}, 32'hee);
    cpu_read(16'hff46, rb);
    chk("abort_readback", {24'h0, rb}, 32'h0);

    // Second register write at cycle 50
    for (int k = 0; k < 160; k++) mem[16'hc100 + 16'(k)] = 8'(k) ^ 8'ha5;
    push_xfer(8'hc0, 8'h5a);
    cpu_write(16'hff46, 8'hc0);
    repeat (48) begin @(posedge clockgb); #1; end
    cpu_write(16'hff46, 8'hc1);
`ifdef OAM_DMA_RESTART_EN
    chk("restart_rd_left", rd_q.size(), 135);
    chk("restart_wr_left", wr_q.size(), 135);
    rd_q.delete();
    wr_q.delete();
    rd_seen = 1'b0;
    push_xfer(8'hc1, 8'ha5);
    wait_busy(n);
    chk("restart_busy_cycles", n, 320);
    chk("restart_first_rd", {16'h0, first_rd}, 32'hc100);
`else
    wait_busy(n);
    chk("norestart_busy_left", n, 270);
`endif
    chk("second_rd_left", rd_q.size(), 0);
    chk("second_wr_left", wr_q.size(), 0);
    cpu_read(16'hff46, rb);
    chk("second_readback", {24'h0, rb}, 32'hc1);

    repeat (4) @(posedge clockgb);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 The block SHALL have the parameter REG_ADDR, default 16'hff46, giving the DMA start register address.
REQ-002 The block SHALL have the parameter OAM_BASE, default 16'hfe00, giving the destination base address.
REQ-003 The block SHALL have the parameter LENGTH, default 160, giving the bytes moved per transfer.
REQ-004 clockgb  in  1  system clock; all state changes on its rising edge.
REQ-005 resetn  in  1  reset; one clock, synchronous reset, active-low.
REQ-006 address  in  16  CPU bus address (responder side).
REQ-007 outdata  in  8  CPU write data.
REQ-008 data  out  8  register readback onto the wired-OR bus; 8'h00 when not selected.
REQ-009 load, store  in  1 each  CPU read and write strobes.
REQ-010 dma_address  out  16  initiator bus address.
REQ-011 dma_outdata  out  8  initiator write data.
REQ-012 dma_indata  in  8  OR-combined responder read data.
REQ-013 dma_load, dma_store  out  1 each  initiator read and write strobes.
REQ-014 busy  out  1  high while the block owns the bus; top level muxes dma_* over CPU signals when high.

Function
REQ-015 The FSM SHALL have the states IDLE, READ and WRITE.
REQ-016 When store=1 and address==REG_ADDR in IDLE, the block SHALL latch outdata into src_hi, clear index i to 0, and enter READ on the next cycle.
REQ-017 The source high byte SHALL be src_hi when src_hi<=8'hdf, and src_hi-8'h20 for 8'he0..8'hff (echo onto C0-DF).
REQ-018 In READ: dma_address={srchigh,8'h00}+i, dma_load=1, dma_store=0; the next state SHALL be WRITE.
REQ-019 In WRITE: dma_address=OAM_BASE+i, dma_store=1, dma_load=0, and dma_outdata SHALL equal the dma_indata captured at the end of the preceding READ cycle.
REQ-020 On leaving WRITE, i SHALL increment; if i==LENGTH-1 the next state SHALL be IDLE, otherwise READ.
REQ-021 One transfer SHALL take exactly 2*LENGTH cycles (320 at default), and busy SHALL be high in every READ and WRITE cycle only.
REQ-022 i SHALL be 8 bits wide; address sums SHALL be 16-bit, with the low byte not carrying beyond 8'hff for LENGTH<=256.
REQ-023 When load=1 and address==REG_ADDR, data SHALL equal the last written src_hi, in any state.
REQ-024 Outside READ and WRITE, dma_address, dma_outdata, dma_load and dma_store SHALL all be 0.
REQ-025 CPU strobes to addresses other than REG_ADDR SHALL be ignored by this block.

Reset
REQ-026 When resetn=0 at a clock edge: state=IDLE, i=0, src_hi=8'h00, busy=0, and every dma_* output=0.
REQ-027 Reset asserted mid-transfer SHALL abort the transfer immediately; no further dma_store SHALL be issued.

Configuration
REQ-028 The compile-time macro OAM_DMA_RESTART_EN SHALL select how a register write during a transfer is handled.
REQ-029 With OAM_DMA_RESTART_EN defined: a write to REG_ADDR while busy SHALL relatch src_hi, set i=0, and enter READ on the next cycle.
REQ-030 Without OAM_DMA_RESTART_EN: a write to REG_ADDR while busy SHALL update only the readback value; the active transfer SHALL continue unchanged with its original source.

Verification
REQ-031 Preload C000-C09F with i^8'h5a, write 8'hc0 to FF46 -> busy high for 320 cycles; FE00-FE9F hold i^8'h5a; dma_store pulses exactly 160 times.
REQ-032 Write 8'hf1 to FF46 -> first dma_address is D100 and the last read address is D19F.
REQ-033 Read FF46 after writing 8'h80 -> data=8'h80; a read of FF47 -> data=8'h00.
REQ-034 Drop resetn at cycle 100 of a transfer -> next cycle busy=0 and all dma_* outputs are 0; FE32 onward is unwritten.
REQ-035 Write 8'hc0, then 8'hc1 at cycle 50 -> with OAM_DMA_RESTART_EN: next READ address is C100, and the transfer ends 320 cycles after the second write; without the macro: the transfer completes from C0xx at cycle 320 and readback is 8'hc1.
REQ-036 Check cycle-by-cycle timing -> dma_load and dma_store are never both high, and each dma_outdata equals the dma_indata from the preceding cycle.
